// File: rtl/card_datapath.sv
// Card slot registers for the baccarat round.
// Holds three player and three dealer cards and loads them on controller strobes.
// Derives hand scores and the player third-card value from the stored cards.
// Decodes every slot onto one seven-segment digit.
module card_datapath #(
   parameter int HEX_ACTIVE_LOW = 1
) (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic [3:0] new_card,
   input  logic       hand_clear,
   input  logic       load_pcard1,
   input  logic       load_pcard2,
   input  logic       load_pcard3,
   input  logic       load_dcard1,
   input  logic       load_dcard2,
   input  logic       load_dcard3,
   output logic [3:0] pscore,
   output logic [3:0] dscore,
   output logic [3:0] pcard3,
   output logic       card_err,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);

   logic [3:0] p1, p2, p3, d1, d2, d3;
   logic       card_legal;
   logic [3:0] card_stored;
   logic       any_load;
   logic [4:0] psum, dsum;

   // An illegal code never reaches a slot; the slot reads as empty instead.
   assign card_legal  = (new_card >= 4'd1) && (new_card <= 4'd13);
   assign card_stored = card_legal ? new_card : 4'd0;
   assign any_load    = load_pcard1 | load_pcard2 | load_pcard3 |
                        load_dcard1 | load_dcard2 | load_dcard3;

   // Slot registers and the sticky illegal-card flag; a new round wipes both.
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         p1       <= 4'd0;
         p2       <= 4'd0;
         p3       <= 4'd0;
         d1       <= 4'd0;
         d2       <= 4'd0;
         d3       <= 4'd0;
         card_err <= 1'b0;
      end else if (hand_clear) begin
         p1       <= 4'd0;
         p2       <= 4'd0;
         p3       <= 4'd0;
         d1       <= 4'd0;
         d2       <= 4'd0;
         d3       <= 4'd0;
         card_err <= 1'b0;
      end else begin
         if (load_pcard1) p1 <= card_stored;
         if (load_pcard2) p2 <= card_stored;
         if (load_pcard3) p3 <= card_stored;
         if (load_dcard1) d1 <= card_stored;
         if (load_dcard2) d2 <= card_stored;
         if (load_dcard3) d3 <= card_stored;
         if (any_load && !card_legal) card_err <= 1'b1;
      end
   end

   // Face cards and tens count as zero, as does an empty slot.
   function automatic logic [3:0] game_value(input logic [3:0] c);
      return ((c >= 4'd1) && (c <= 4'd9)) ? c : 4'd0;
   endfunction

   // Sum of three values is at most 27, so two conditional subtractions suffice.
   function automatic logic [3:0] mod10(input logic [4:0] s);
      logic [4:0] r;
      if (s >= 5'd20)      r = s - 5'd20;
      else if (s >= 5'd10) r = s - 5'd10;
      else                 r = s;
      return r[3:0];
   endfunction

   function automatic logic [6:0] seg_low(input logic [3:0] c);
      logic [6:0] pat;
      case (c)
         4'd1:    pat = 7'b0001000;
         4'd2:    pat = 7'b0100100;
         4'd3:    pat = 7'b0110000;
         4'd4:    pat = 7'b0011001;
         4'd5:    pat = 7'b0010010;
         4'd6:    pat = 7'b0000010;
         4'd7:    pat = 7'b1111000;
         4'd8:    pat = 7'b0000000;
         4'd9:    pat = 7'b0010000;
         4'd10:   pat = 7'b1000000;
         4'd11:   pat = 7'b1100001;
         4'd12:   pat = 7'b0011000;
         4'd13:   pat = 7'b0001001;
         default: pat = 7'b1111111;
      endcase
      return pat;
   endfunction

   function automatic logic [6:0] seg(input logic [3:0] c);
      return (HEX_ACTIVE_LOW != 0) ? seg_low(c) : ~seg_low(c);
   endfunction

   assign psum = {1'b0, game_value(p1)} + {1'b0, game_value(p2)} + {1'b0, game_value(p3)};
   assign dsum = {1'b0, game_value(d1)} + {1'b0, game_value(d2)} + {1'b0, game_value(d3)};

   assign pscore = mod10(psum);
   assign dscore = mod10(dsum);
   assign pcard3 = game_value(p3);

   assign HEX0 = seg(p1);
   assign HEX1 = seg(p2);
   assign HEX2 = seg(p3);
   assign HEX3 = seg(d1);
   assign HEX4 = seg(d2);
   assign HEX5 = seg(d3);

endmodule

// File: doc/card_datapath.md
Name: card_datapath

Overview:
- Datapath stage directly upstream of the baccarat round controller.
- Holds the three player and three dealer card registers and loads each one from the incoming card value when the controller's matching load strobe is high.
- Produces the player score, dealer score and player third-card value that the controller's next-state logic consumes.
- Drives six seven-segment digits, one per card slot.

Parameters:
- HEX_ACTIVE_LOW, 1, 1 = segment outputs active-low (board LEDs); 0 = inverted (active-high).

Ports:
- slow_clock  input  1  round clock, shared with the controller.
- resetb  input  1  asynchronous, active-low reset.
- new_card  input  4  card code from the card source: 1=A, 2..10 pip cards, 11=J, 12=Q, 13=K; 0, 14 and 15 are illegal.
- hand_clear  input  1  synchronous clear of all six card slots (new round).
- load_pcard1, load_pcard2, load_pcard3  input  1 each  player slot load strobes from the controller.
- load_dcard1, load_dcard2, load_dcard3  input  1 each  dealer slot load strobes from the controller.
- pscore  output  4  player hand total mod 10, range 0..9.
- dscore  output  4  dealer hand total mod 10, range 0..9.
- pcard3  output  4  game value of player slot 3, range 0..9.
- card_err  output  1  sticky flag: an illegal code was loaded.
- HEX0, HEX1, HEX2  output  7 each  player slots 1..3, segment order {g,f,e,d,c,b,a}.
- HEX3, HEX4, HEX5  output  7 each  dealer slots 1..3, same segment order.

Behaviour:
Registers
- Six 4-bit slot registers, asynchronous reset to 0 (0 = empty slot).
- card_err resets to 0.

Slot loading
- Each slot updates on the posedge of slow_clock while its load strobe is high: slot <= new_card.
- Load-to-score latency: the new value is visible at the outputs one cycle after the strobe is sampled.
- Several strobes high in the same cycle: every strobed slot captures the same new_card. This is legal.
- Illegal new_card (0, 14, 15) with any strobe high: the strobed slot(s) store 0 and card_err is set.

Clearing
- hand_clear high: all slots <= 0 and card_err <= 0.
- hand_clear takes priority over any load in the same cycle.
- card_err otherwise holds until reset or hand_clear.

Game value and scores
- Game value of a slot: codes 1..9 map to 1..9; codes 10..13 and the empty code 0 map to 0.
- pscore = (p1 + p2 + p3) mod 10 over game values. dscore is computed the same way over the dealer slots.
- Compute each sum in a 5-bit intermediate (maximum 27), then reduce by subtracting 10 or 20. Use no divider.
- pcard3 = game value of player slot 3.
- pscore, dscore and pcard3 are purely combinational from the slot registers: no extra register stage and zero cycles after a register update.

Seven-segment decode
- Each HEX digit is a combinational decode of its slot register.
- Active-low patterns when HEX_ACTIVE_LOW = 1:
  - 0 (empty) = 1111111 (blank)
  - 1 = 0001000 (A)
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - 10 = 1000000 (0)
  - 11 = 1100001 (J)
  - 12 = 0011000 (q)
  - 13 = 0001001 (K)
  - 14, 15 = 1111111 (blank; unreachable, since illegal codes store 0)
- HEX_ACTIVE_LOW = 0: every pattern is bitwise inverted.

Reset
- resetb low at any time, including mid-round: all slots and card_err clear immediately without waiting for a clock edge.
- Immediately after reset: pscore = 0, dscore = 0, pcard3 = 0, all HEX blank.
- Strobes are ignored while resetb is low.

Test Plan:
- Reset, then no strobes -> pscore = dscore = pcard3 = 0, card_err = 0, all HEX = 1111111.
- Load P1 = 9, P2 = 8, D1 = 13, D2 = 5, one strobe per cycle -> pscore = 7, dscore = 5, HEX3 = 0001001, HEX4 = 0010010.
- Then load P3 = 6 -> pscore = 3 (sum 23), pcard3 = 6. Load D3 = 10 -> dscore = 5 and HEX5 = 1000000.
- Load P1 = 9, P2 = 9, P3 = 9 -> pscore = 7, exercising the maximum sum 27 mod 10.
- new_card = 14 with load_dcard1 -> D1 = 0, HEX3 blank, card_err = 1. A following legal load leaves card_err at 1. hand_clear -> card_err = 0 and all slots empty.
- hand_clear and load_pcard1 (new_card = 5) in the same cycle -> P1 = 0.
- load_pcard2 and load_dcard2 together with new_card = 4 -> both slots = 4.
- Assert resetb low between clock edges mid-round -> outputs return to reset values before the next edge.
